// File: rtl/fib_pkg.sv
// ---------------------------------------------------------------------------
// fib_pkg
// Shared definitions for the FIB forwarder: metadata encodings, the RX and
// TX state encodings, the table entry layout for the default geometry and a
// helper that clamps a configured match length to the prefix length.
// No ports (package).
// ---------------------------------------------------------------------------
package fib_pkg;

    localparam int         META_INTEREST_BIT = 6;
    localparam logic [7:0] META_INTEREST     = 8'h70;
    localparam logic [7:0] META_DATA         = 8'h30;

    // Default geometry of a table entry (8-byte prefix, 4 faces).
    localparam int FIB_PREFIX_BYTES = 8;
    localparam int FIB_FACE_W       = 2;

    typedef enum logic [1:0] {
        R_IDLE,
        R_HDR,
        R_WAIT,
        R_PAY
    } rx_state_t;

    typedef enum logic [2:0] {
        T_IDLE,
        T_LOOK,
        T_META,
        T_PFX,
        T_PAY
    } tx_state_t;

    typedef struct packed {
        logic                          en;
        logic [3:0]                    len;
        logic [8*FIB_PREFIX_BYTES-1:0] prefix;
        logic [FIB_FACE_W-1:0]         face;
    } fib_entry_t;

    // Lengths beyond the prefix width mean "whole prefix".
    function automatic logic [3:0] clamp_len(input logic [3:0] len, input int pb);
        if (int'(len) > pb) begin
            return 4'(pb);
        end
        return len;
    endfunction

endpackage

// File: rtl/fib_lpm_lookup.sv
// ---------------------------------------------------------------------------
// fib_lpm_lookup
// DEPTH-entry forwarding table with a one-cycle longest-prefix match.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cfg_we/idx/en/len/prefix/face   table write port (lands on the clock edge)
//   look_en                  key is presented this cycle
//   key                      prefix to route
//   res_valid                one-cycle pulse, cycle after look_en
//   res_hit                  registered: some entry matched
//   res_face                 registered: chosen face (DEFAULT_FACE on miss)
// ---------------------------------------------------------------------------
module fib_lpm_lookup #(
    parameter int PB           = 8,
    parameter int DEPTH        = 8,
    parameter int FACE_W       = 2,
    parameter int IDX_W        = 3,
    parameter int DEFAULT_FACE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic              cfg_en,
    input  logic [3:0]        cfg_len,
    input  logic [8*PB-1:0]   cfg_prefix,
    input  logic [FACE_W-1:0] cfg_face,
    input  logic              look_en,
    input  logic [8*PB-1:0]   key,
    output logic              res_valid,
    output logic              res_hit,
    output logic [FACE_W-1:0] res_face
);
    import fib_pkg::*;

    typedef struct packed {
        logic              en;
        logic [3:0]        len;
        logic [8*PB-1:0]   prefix;
        logic [FACE_W-1:0] face;
    } entry_t;

    // Every entry is compared in parallel, so the table lives in flops.
    entry_t fib_table_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fib_table_reg[i].en <= 1'b0;
            end
        end else if (cfg_we) begin
            fib_table_reg[cfg_idx] <= '{en:     cfg_en,
                                        len:    clamp_len(cfg_len, PB),
                                        prefix: cfg_prefix,
                                        face:   cfg_face};
        end
    end

    logic [DEPTH-1:0] hit;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PB-1:0] byte_ok;
            // gb = 0 is the most significant (first transmitted) byte; bytes
            // beyond the entry length are don't-care.
            for (genvar gb = 0; gb < PB; gb++) begin : g_byte
                assign byte_ok[gb] = (gb >= int'(fib_table_reg[gi].len)) ||
                                     (key[8*(PB-gb)-1 -: 8] ==
                                      fib_table_reg[gi].prefix[8*(PB-gb)-1 -: 8]);
            end
            assign hit[gi] = fib_table_reg[gi].en && (&byte_ok);
        end
    endgenerate

    logic              found;
    logic [3:0]        best_len;
    logic [FACE_W-1:0] best_face;

    // Strictly-greater replaces, so on equal lengths the lowest index stays.
    always_comb begin
        found     = 1'b0;
        best_len  = '0;
        best_face = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (hit[i] && (!found || (fib_table_reg[i].len > best_len))) begin
                found     = 1'b1;
                best_len  = fib_table_reg[i].len;
                best_face = fib_table_reg[i].face;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_hit   <= 1'b0;
            res_face  <= '0;
        end else begin
            res_valid <= look_en;
            if (look_en) begin
                res_hit  <= found;
                res_face <= found ? best_face : FACE_W'(DEFAULT_FACE);
            end
        end
    end

endmodule

// File: rtl/fib_forwarder.sv
// ---------------------------------------------------------------------------
// fib_forwarder
// Byte-serial NDN packet engine between an SPI face and the PIT.
//   RX: meta + prefix bytes -> header to PIT, then payload bytes (data only).
//   TX: PIT request -> longest-prefix lookup -> meta, prefix, payload to SPI.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   rx_valid/rx_data                  SPI byte stream in (no backpressure)
//   pit_out_valid/ready/prefix/meta   parsed header to PIT
//   rejected                          PIT drops the rest of the payload
//   rx_pay_valid/rx_pay_data          payload bytes to PIT
//   rx_overflow                       pulse: byte arrived while header held
//   pit_in_valid/ready/prefix/meta    send request from PIT
//   pit_data_valid/ready/pit_data     outgoing payload from PIT
//   tx_valid/ready/tx_data/tx_face    byte stream to SPI and its face
//   fib_miss                          pulse: lookup found no entry
//   cfg_we/idx/en/len/prefix/face     table write port
// Build option: FIB_DEFAULT_ROUTE_EN sends missed packets to DEFAULT_FACE
// instead of dropping them.
// ---------------------------------------------------------------------------
module fib_forwarder #(
    parameter int PREFIX_BYTES = 8,
    parameter int DATA_BYTES   = 32,
    parameter int DEPTH        = 8,
    parameter int NUM_FACES    = 4,
    parameter int DEFAULT_FACE = 0,
    localparam int FACE_W      = (NUM_FACES > 1) ? $clog2(NUM_FACES) : 1,
    localparam int IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_valid,
    input  logic [7:0]                rx_data,
    output logic                      pit_out_valid,
    input  logic                      pit_out_ready,
    output logic [8*PREFIX_BYTES-1:0] pit_out_prefix,
    output logic [7:0]                pit_out_meta,
    input  logic                      rejected,
    output logic                      rx_pay_valid,
    output logic [7:0]                rx_pay_data,
    output logic                      rx_overflow,
    input  logic                      pit_in_valid,
    output logic                      pit_in_ready,
    input  logic [8*PREFIX_BYTES-1:0] pit_in_prefix,
    input  logic [7:0]                pit_in_meta,
    input  logic                      pit_data_valid,
    output logic                      pit_data_ready,
    input  logic [7:0]                pit_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic [7:0]                tx_data,
    output logic [FACE_W-1:0]         tx_face,
    output logic                      fib_miss,
    input  logic                      cfg_we,
    input  logic [IDX_W-1:0]          cfg_idx,
    input  logic                      cfg_en,
    input  logic [3:0]                cfg_len,
    input  logic [8*PREFIX_BYTES-1:0] cfg_prefix,
    input  logic [FACE_W-1:0]         cfg_face
);
    import fib_pkg::*;

    localparam int PB    = PREFIX_BYTES;
    localparam int MAXB  = (DATA_BYTES > PB) ? DATA_BYTES : PB;
    localparam int CNT_W = $clog2(MAXB + 1);

    // ---------------- RX path ----------------
    rx_state_t        rx_state_reg, rx_state_next;
    logic [CNT_W-1:0] rx_cnt_reg, rx_cnt_next;
    logic [7:0]       rx_meta_reg, rx_meta_next;
    logic [8*PB-1:0]  rx_prefix_reg, rx_prefix_next;
    logic             rej_reg, rej_next;
    logic             pay_valid_reg, pay_valid_next;
    logic [7:0]       pay_data_reg, pay_data_next;
    logic             overflow_reg, overflow_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_reg  <= R_IDLE;
            rx_cnt_reg    <= '0;
            rx_meta_reg   <= '0;
            rx_prefix_reg <= '0;
            rej_reg       <= 1'b0;
            pay_valid_reg <= 1'b0;
            pay_data_reg  <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            rx_state_reg  <= rx_state_next;
            rx_cnt_reg    <= rx_cnt_next;
            rx_meta_reg   <= rx_meta_next;
            rx_prefix_reg <= rx_prefix_next;
            rej_reg       <= rej_next;
            pay_valid_reg <= pay_valid_next;
            pay_data_reg  <= pay_data_next;
            overflow_reg  <= overflow_next;
        end
    end

    always_comb begin
        rx_state_next  = rx_state_reg;
        rx_cnt_next    = rx_cnt_reg;
        rx_meta_next   = rx_meta_reg;
        rx_prefix_next = rx_prefix_reg;
        rej_next       = rej_reg;
        pay_valid_next = 1'b0;
        pay_data_next  = pay_data_reg;
        overflow_next  = 1'b0;
        case (rx_state_reg)
            R_IDLE: begin
                if (rx_valid) begin
                    rx_meta_next  = rx_data;
                    rx_cnt_next   = '0;
                    rx_state_next = R_HDR;
                end
            end
            R_HDR: begin
                if (rx_valid) begin
                    rx_prefix_next = (rx_prefix_reg << 8) | (8*PB)'(rx_data);
                    if (rx_cnt_reg == CNT_W'(PB - 1)) begin
                        rx_state_next = R_WAIT;
                    end else begin
                        rx_cnt_next = rx_cnt_reg + 1'b1;
                    end
                end
            end
            R_WAIT: begin
                if (rx_valid) begin
                    overflow_next = 1'b1;
                end
                if (pit_out_ready) begin
                    if (rx_meta_reg[META_INTEREST_BIT]) begin
                        rx_state_next = R_IDLE;
                    end else begin
                        rx_state_next = R_PAY;
                        rx_cnt_next   = '0;
                        rej_next      = 1'b0;
                    end
                end
            end
            R_PAY: begin
                if (rejected) begin
                    rej_next = 1'b1;
                end
                if (rx_valid) begin
                    // A rejection in the same cycle already drops this byte.
                    pay_valid_next = !(rej_reg || rejected);
                    pay_data_next  = rx_data;
                    if (rx_cnt_reg == CNT_W'(DATA_BYTES - 1)) begin
                        rx_state_next = R_IDLE;
                    end else begin
                        rx_cnt_next = rx_cnt_reg + 1'b1;
                    end
                end
            end
            default: rx_state_next = R_IDLE;
        endcase
    end

    assign pit_out_valid  = (rx_state_reg == R_WAIT);
    assign pit_out_prefix = rx_prefix_reg;
    assign pit_out_meta   = rx_meta_reg;
    assign rx_pay_valid   = pay_valid_reg;
    assign rx_pay_data    = pay_data_reg;
    assign rx_overflow    = overflow_reg;

    // ---------------- TX path ----------------
    tx_state_t        tx_state_reg, tx_state_next;
    logic [CNT_W-1:0] tx_cnt_reg, tx_cnt_next;
    logic [7:0]       tx_meta_reg, tx_meta_next;
    logic [8*PB-1:0]  tx_prefix_reg, tx_prefix_next;
    logic             in_ready_reg, in_ready_next;
    logic             res_valid, res_hit, route_ok;
    logic [FACE_W-1:0] res_face;

    fib_lpm_lookup #(
        .PB           (PB),
        .DEPTH        (DEPTH),
        .FACE_W       (FACE_W),
        .IDX_W        (IDX_W),
        .DEFAULT_FACE (DEFAULT_FACE)
    ) u_lookup (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_en     (cfg_en),
        .cfg_len    (cfg_len),
        .cfg_prefix (cfg_prefix),
        .cfg_face   (cfg_face),
        .look_en    (tx_state_reg == T_LOOK),
        .key        (tx_prefix_reg),
        .res_valid  (res_valid),
        .res_hit    (res_hit),
        .res_face   (res_face)
    );

`ifdef FIB_DEFAULT_ROUTE_EN
    assign route_ok = 1'b1;
`else
    assign route_ok = res_hit;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_reg  <= T_IDLE;
            tx_cnt_reg    <= '0;
            tx_meta_reg   <= '0;
            tx_prefix_reg <= '0;
            in_ready_reg  <= 1'b0;
        end else begin
            tx_state_reg  <= tx_state_next;
            tx_cnt_reg    <= tx_cnt_next;
            tx_meta_reg   <= tx_meta_next;
            tx_prefix_reg <= tx_prefix_next;
            in_ready_reg  <= in_ready_next;
        end
    end

    always_comb begin
        tx_state_next  = tx_state_reg;
        tx_cnt_next    = tx_cnt_reg;
        tx_meta_next   = tx_meta_reg;
        tx_prefix_next = tx_prefix_reg;
        tx_valid       = 1'b0;
        tx_data        = '0;
        pit_data_ready = 1'b0;
        case (tx_state_reg)
            T_IDLE: begin
                if (pit_in_valid && in_ready_reg) begin
                    tx_meta_next   = pit_in_meta;
                    tx_prefix_next = pit_in_prefix;
                    tx_state_next  = T_LOOK;
                end
            end
            T_LOOK: tx_state_next = T_META;
            T_META: begin
                // The lookup result is registered and holds until the next
                // lookup, so it is valid for every cycle spent here.
                if (route_ok) begin
                    tx_valid = 1'b1;
                    tx_data  = tx_meta_reg;
                    if (tx_ready) begin
                        tx_cnt_next   = '0;
                        tx_state_next = T_PFX;
                    end
                end else begin
                    tx_state_next = T_IDLE;
                end
            end
            T_PFX: begin
                tx_valid = 1'b1;
                tx_data  = tx_prefix_reg[8*PB-1 -: 8];
                if (tx_ready) begin
                    tx_prefix_next = tx_prefix_reg << 8;
                    if (tx_cnt_reg == CNT_W'(PB - 1)) begin
                        tx_cnt_next   = '0;
                        tx_state_next = tx_meta_reg[META_INTEREST_BIT] ? T_IDLE : T_PAY;
                    end else begin
                        tx_cnt_next = tx_cnt_reg + 1'b1;
                    end
                end
            end
            T_PAY: begin
                tx_valid       = pit_data_valid;
                tx_data        = pit_data;
                pit_data_ready = tx_ready;
                if (pit_data_valid && tx_ready) begin
                    if (tx_cnt_reg == CNT_W'(DATA_BYTES - 1)) begin
                        tx_state_next = T_IDLE;
                    end else begin
                        tx_cnt_next = tx_cnt_reg + 1'b1;
                    end
                end
            end
            default: tx_state_next = T_IDLE;
        endcase
        // Registered so that ready is low throughout reset.
        in_ready_next = (tx_state_next == T_IDLE);
    end

    assign pit_in_ready = in_ready_reg;
    assign tx_face      = res_face;
    assign fib_miss     = res_valid && !res_hit;

endmodule

// File: tb/tb_fib_forwarder.sv
// ---------------------------------------------------------------------------
// tb_fib_forwarder
// Directed bench for fib_forwarder: TX interest routing, RX header hold and
// overflow, RX payload rejection, longest-prefix / tie / concurrent-write
// behaviour, miss handling (FIB_DEFAULT_ROUTE_EN aware), a data send with a
// stalling sink, and reset in the middle of a packet.
// ---------------------------------------------------------------------------
module tb_fib_forwarder;
    import fib_pkg::*;

    localparam int PB     = 8;
    localparam int DB     = 32;
    localparam int FACE_W = 2;
    localparam int IDX_W  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              pit_out_valid;
    logic              pit_out_ready;
    logic [8*PB-1:0]   pit_out_prefix;
    logic [7:0]        pit_out_meta;
    logic              rejected;
    logic              rx_pay_valid;
    logic [7:0]        rx_pay_data;
    logic              rx_overflow;
    logic              pit_in_valid;
    logic              pit_in_ready;
    logic [8*PB-1:0]   pit_in_prefix;
    logic [7:0]        pit_in_meta;
    logic              pit_data_valid;
    logic              pit_data_ready;
    logic [7:0]        pit_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [7:0]        tx_data;
    logic [FACE_W-1:0] tx_face;
    logic              fib_miss;
    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_idx;
    logic              cfg_en;
    logic [3:0]        cfg_len;
    logic [8*PB-1:0]   cfg_prefix;
    logic [FACE_W-1:0] cfg_face;

    fib_forwarder dut (
        .clk            (clk),
        .rst            (rst),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .pit_out_valid  (pit_out_valid),
        .pit_out_ready  (pit_out_ready),
        .pit_out_prefix (pit_out_prefix),
        .pit_out_meta   (pit_out_meta),
        .rejected       (rejected),
        .rx_pay_valid   (rx_pay_valid),
        .rx_pay_data    (rx_pay_data),
        .rx_overflow    (rx_overflow),
        .pit_in_valid   (pit_in_valid),
        .pit_in_ready   (pit_in_ready),
        .pit_in_prefix  (pit_in_prefix),
        .pit_in_meta    (pit_in_meta),
        .pit_data_valid (pit_data_valid),
        .pit_data_ready (pit_data_ready),
        .pit_data       (pit_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .tx_data        (tx_data),
        .tx_face        (tx_face),
        .fib_miss       (fib_miss),
        .cfg_we         (cfg_we),
        .cfg_idx        (cfg_idx),
        .cfg_en         (cfg_en),
        .cfg_len        (cfg_len),
        .cfg_prefix     (cfg_prefix),
        .cfg_face       (cfg_face)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]        cap [64];
    int                cap_n;
    int                miss_n;
    logic [FACE_W-1:0] cap_face;
    bit                face_ok;
    logic [7:0]        pay_mem [DB];
    int                pidx;
    logic [7:0]        exp_bytes [64];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int idx, input bit en, input int len,
                             input logic [8*PB-1:0] pfx, input int face);
        cfg_idx    = IDX_W'(idx);
        cfg_en     = en;
        cfg_len    = 4'(len);
        cfg_prefix = pfx;
        cfg_face   = FACE_W'(face);
        cfg_we     = 1'b1;
        step();
        cfg_we     = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        step();
        rx_valid = 1'b0;
    endtask

    // Returns after the handshake edge (TX FSM then sits in T_LOOK).
    task automatic send_req(input logic [8*PB-1:0] pfx, input logic [7:0] meta);
        bit done;
        done          = 1'b0;
        pit_in_prefix = pfx;
        pit_in_meta   = meta;
        pit_in_valid  = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            if (pit_in_ready) done = 1'b1;
            step();
        end
        pit_in_valid = 1'b0;
        check("req_accepted", 64'(done), 64'd1);
    endtask

    // Runs a fixed window acting as SPI sink and PIT payload source.
    task automatic tx_collect(input int ncyc, input bit toggle);
        cap_n   = 0;
        miss_n  = 0;
        pidx    = 0;
        face_ok = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            tx_ready       = toggle ? c[0] : 1'b1;
            pit_data_valid = (pidx < DB);
            pit_data       = (pidx < DB) ? pay_mem[pidx] : 8'h00;
            #1;
            if (fib_miss) miss_n++;
            if (tx_valid && tx_ready) begin
                if (cap_n < 64) cap[cap_n] = tx_data;
                if (cap_n == 0) cap_face = tx_face;
                else if (tx_face !== cap_face) face_ok = 1'b0;
                cap_n++;
            end
            if (pit_data_valid && pit_data_ready) pidx++;
            @(posedge clk);
            #1;
        end
        tx_ready       = 1'b0;
        pit_data_valid = 1'b0;
    endtask

    task automatic load_exp(input logic [7:0] meta, input logic [8*PB-1:0] pfx);
        logic [8*PB-1:0] p;
        p = pfx;
        exp_bytes[0] = meta;
        for (int i = 0; i < PB; i++) begin
            exp_bytes[1+i] = p[8*PB-1 -: 8];
            p = p << 8;
        end
        for (int i = 0; i < DB; i++) exp_bytes[1+PB+i] = pay_mem[i];
    endtask

    initial begin
        int beats;
        int nexp_miss;
        rst = 1'b1; rx_valid = 0; rx_data = 0; pit_out_ready = 0; rejected = 0;
        pit_in_valid = 0; pit_in_prefix = 0; pit_in_meta = 0;
        pit_data_valid = 0; pit_data = 0; tx_ready = 0;
        cfg_we = 0; cfg_idx = 0; cfg_en = 0; cfg_len = 0; cfg_prefix = 0; cfg_face = 0;
        for (int i = 0; i < DB; i++) pay_mem[i] = 8'(8'hA0 + i);

        // ---- reset state ----
        step(); step(); step();
        check("rst_pit_out_valid", 64'(pit_out_valid), 64'd0);
        check("rst_tx_valid",      64'(tx_valid),      64'd0);
        check("rst_pit_in_ready",  64'(pit_in_ready),  64'd0);
        check("rst_rx_pay_valid",  64'(rx_pay_valid),  64'd0);
        check("rst_fib_miss",      64'(fib_miss),      64'd0);
        rst = 1'b0;
        step();
        check("idle_pit_in_ready", 64'(pit_in_ready), 64'd1);

        // ---- TX interest on a full-length entry ----
        cfg_write(0, 1, 8, 64'h0000FFFF0000FFFF, 2);
        send_req(64'h0000FFFF0000FFFF, META_INTEREST);
        tx_collect(20, 1'b0);
        load_exp(META_INTEREST, 64'h0000FFFF0000FFFF);
        $display("TX interest: %0d bytes face=%0d", cap_n, cap_face);
        check("int_count", 64'(cap_n), 64'd9);
        for (int i = 0; i < 9; i++) check($sformatf("int_byte%0d", i), 64'(cap[i]), 64'(exp_bytes[i]));
        check("int_face", 64'(cap_face), 64'd2);
        check("int_face_const", 64'(face_ok), 64'd1);
        check("int_no_miss", 64'(miss_n), 64'd0);

        // ---- RX interest held, overflow byte ----
        rx_byte(META_INTEREST);
        for (int i = 0; i < PB; i++) rx_byte((i % 4 < 2) ? 8'h00 : 8'hFF);
        $display("RX interest header: meta=%0h prefix=%0h", pit_out_meta, pit_out_prefix);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("hold_valid%0d", c), 64'(pit_out_valid), 64'd1);
            check($sformatf("hold_prefix%0d", c), pit_out_prefix, 64'h0000FFFF0000FFFF);
            if (c == 2) begin
                rx_byte(8'hAB);
                check("overflow_pulse", 64'(rx_overflow), 64'd1);
            end else begin
                step();
                check($sformatf("no_overflow%0d", c), 64'(rx_overflow), 64'd0);
            end
        end
        check("hold_meta", 64'(pit_out_meta), 64'h70);
        pit_out_ready = 1'b1;
        step();
        pit_out_ready = 1'b0;
        check("hdr_released", 64'(pit_out_valid), 64'd0);

        // ---- RX data with rejection at payload byte 4 ----
        rx_byte(META_DATA);
        for (int i = 0; i < PB; i++) rx_byte(8'(i + 1));
        check("data_hdr_valid", 64'(pit_out_valid), 64'd1);
        check("data_hdr_prefix", pit_out_prefix, 64'h0102030405060708);
        check("data_hdr_meta", 64'(pit_out_meta), 64'h30);
        pit_out_ready = 1'b1;
        step();
        pit_out_ready = 1'b0;
        beats = 0;
        for (int k = 0; k < DB; k++) begin
            rejected = (k == 4);
            rx_byte(8'(8'h10 + k));
            rejected = 1'b0;
            if (rx_pay_valid) begin
                check($sformatf("pay_data%0d", k), 64'(rx_pay_data), 64'(8'h10 + k));
                beats++;
            end
        end
        step();
        $display("RX data: %0d payload beats delivered", beats);
        check("pay_beats", 64'(beats), 64'd4);

        // ---- longest prefix, concurrent write, tie ----
        cfg_write(0, 1, 2, 64'h0000000000000000, 1);
        cfg_write(1, 1, 4, 64'h0000FFFF00000000, 3);
        cfg_write(5, 1, 2, 64'h0000000000000000, 2);
        send_req(64'h0000FFFF0000FFF0, META_INTEREST);
        cfg_write(1, 0, 4, 64'h0000FFFF00000000, 3);   // lands during T_LOOK
        tx_collect(20, 1'b0);
        $display("TX lpm: %0d bytes face=%0d", cap_n, cap_face);
        check("lpm_count", 64'(cap_n), 64'd9);
        check("lpm_face_long", 64'(cap_face), 64'd3);
        send_req(64'h0000FFFF0000FFF0, META_INTEREST);
        tx_collect(20, 1'b0);
        $display("TX lpm after removal: %0d bytes face=%0d", cap_n, cap_face);
        check("lpm_face_tie_low_idx", 64'(cap_face), 64'd1);

        // ---- miss ----
        cfg_write(0, 0, 2, 64'h0, 1);
        cfg_write(5, 0, 2, 64'h0, 2);
        cfg_write(1, 1, 4, 64'h0000FFFF00000000, 3);
        send_req(64'h0000FF0F0000FFF0, META_INTEREST);
        tx_collect(20, 1'b0);
`ifdef FIB_DEFAULT_ROUTE_EN
        nexp_miss = 9;
`else
        nexp_miss = 0;
`endif
        $display("TX miss: %0d bytes, %0d miss pulses", cap_n, miss_n);
        check("miss_pulses", 64'(miss_n), 64'd1);
        check("miss_tx_bytes", 64'(cap_n), 64'(nexp_miss));
        if (cap_n > 0) check("miss_default_face", 64'(cap_face), 64'd0);
        check("miss_ready_back", 64'(pit_in_ready), 64'd1);

        // ---- data send with stalling sink ----
        send_req(64'h0000FFFF12345678, META_DATA);
        tx_collect(100, 1'b1);
        load_exp(META_DATA, 64'h0000FFFF12345678);
        $display("TX data: %0d bytes face=%0d", cap_n, cap_face);
        check("data_count", 64'(cap_n), 64'd41);
        for (int i = 0; i < 41; i++) check($sformatf("data_byte%0d", i), 64'(cap[i]), 64'(exp_bytes[i]));
        check("data_face", 64'(cap_face), 64'd3);
        check("data_face_const", 64'(face_ok), 64'd1);
        check("data_pit_consumed", 64'(pidx), 64'd32);

        // ---- reset mid-packet ----
        rx_byte(META_DATA);
        for (int i = 0; i < PB; i++) rx_byte(8'h55);
        send_req(64'h0000FFFF12345678, META_DATA);
        tx_collect(10, 1'b0);
        tx_ready = 1'b1;
        pit_data_valid = 1'b1;
        #1;
        check("pre_rst_tx_valid", 64'(tx_valid), 64'd1);
        check("pre_rst_hdr_valid", 64'(pit_out_valid), 64'd1);
        rst = 1'b1;
        step();
        $display("Reset mid-packet applied");
        check("mid_rst_tx_valid",       64'(tx_valid),       64'd0);
        check("mid_rst_tx_data",        64'(tx_data),        64'd0);
        check("mid_rst_tx_face",        64'(tx_face),        64'd0);
        check("mid_rst_pit_data_ready", 64'(pit_data_ready), 64'd0);
        check("mid_rst_pit_in_ready",   64'(pit_in_ready),   64'd0);
        check("mid_rst_pit_out_valid",  64'(pit_out_valid),  64'd0);
        check("mid_rst_rx_pay_valid",   64'(rx_pay_valid),   64'd0);
        tx_ready = 1'b0;
        pit_data_valid = 1'b0;
        rst = 1'b0;
        step();
        // Table valid bits were cleared, so a formerly routable prefix misses.
        send_req(64'h0000FFFF0000FFFF, META_INTEREST);
        tx_collect(20, 1'b0);
        $display("TX after reset: %0d bytes, %0d miss pulses", cap_n, miss_n);
        check("post_rst_miss", 64'(miss_n), 64'd1);
        check("post_rst_bytes", 64'(cap_n), 64'(nexp_miss));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
